// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring divider
// sharing one accumulator, with start/busy/done handshake and flush abort.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q;
    logic [2:0]      op_q;
    logic [CntW-1:0] count_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] opnd_q;
    logic            neg_q;
    logic            neg_rem_q;

    // Acceptance-time decode
    logic            a_signed, b_signed, a_neg, b_neg, is_div;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed && operand_a[XLEN-1];
        b_neg    = b_signed && operand_b[XLEN-1];
        mag_a    = a_neg ? (~operand_a + 1'b1) : operand_a;
        mag_b    = b_neg ? (~operand_b + 1'b1) : operand_b;
        is_div   = funct3[2];
        div_zero = is_div && (operand_b == '0);
        div_ovf  = is_div && !funct3[0] && (operand_a == MinNeg) && (operand_b == '1);
        if (div_zero) begin
            special_res = funct3[1] ? operand_a : '1;
        end else begin
            special_res = funct3[1] ? '0 : MinNeg;
        end
    end

    // One iteration step for each engine
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_shift;
    logic [XLEN-1:0]   rem_diff, rem_next, quo_next;
    logic              q_bit;
    logic [2*XLEN-1:0] div_acc_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Guard bit lives in rem_shift; a successful subtract always fits in XLEN bits.
        rem_shift    = {rem_q, acc_q[XLEN-1]};
        q_bit        = (rem_shift >= {1'b0, opnd_q});
        rem_diff     = rem_shift[XLEN-1:0] - opnd_q;
        rem_next     = q_bit ? rem_diff : rem_shift[XLEN-1:0];
        quo_next     = {acc_q[XLEN-2:0], q_bit};
        div_acc_next = {acc_q[2*XLEN-1:XLEN], quo_next};
    end

    // Sign-corrected final result, taken from the last iteration's output
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res, quo_res, rem_res, calc_res;

    always_comb begin
        prod     = neg_q ? (~mul_next + 1'b1) : mul_next;
        mul_res  = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        quo_res  = neg_q ? (~quo_next + 1'b1) : quo_next;
        rem_res  = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
        calc_res = op_q[2] ? (op_q[1] ? rem_res : quo_res) : mul_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            count_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start && !flush) begin
                        op_q      <= funct3;
                        neg_q     <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        busy      <= 1'b1;
                        if (div_zero || div_ovf) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            result  <= special_res;
                        end else begin
                            state_q <= StCalc;
                            count_q <= CntW'(XLEN - 1);
                            opnd_q  <= is_div ? mag_b : mag_a;
                            acc_q   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                            rem_q   <= '0;
                        end
                    end
                end
                StCalc: begin
                    if (flush) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        if (op_q[2]) begin
                            acc_q <= div_acc_next;
                            rem_q <= rem_next;
                        end else begin
                            acc_q <= mul_next;
                        end
                        if (count_q == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            result  <= calc_res;
                        end else begin
                            count_q <= count_q - CntW'(1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M vectors plus randomized ops
// checked against a 64-bit arithmetic reference model.
module tb_muldiv_sequencer;

    localparam int XLEN = 32;
    localparam logic [31:0] MinNeg = 32'h8000_0000;

    logic        clk, rst, start, flush, busy, done;
    logic [2:0]  funct3;
    logic [31:0] operand_a, operand_b, result;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: full 64-bit products and native signed/unsigned division.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        int qa, qb;
        sa = {{32{a[31]}}, a};
        ua = {32'b0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        qa = a;
        qb = b;
        p  = 64'd0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MinNeg && b == 32'hFFFF_FFFF) return MinNeg;
                return 32'(qa / qb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MinNeg && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(qa % qb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == MinNeg && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MinNeg;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drives one start and waits (bounded) for done; lat = -1 on timeout.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit wait_first, output logic [31:0] res, output int lat,
                          output bit busy_ok);
        bit fin;
        if (wait_first) @(negedge clk);
        start     = 1'b1;
        funct3    = f;
        operand_a = a;
        operand_b = b;
        lat       = 0;
        busy_ok   = 1'b1;
        fin       = 1'b0;
        while (!fin) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) fin = 1'b1;
            else if (lat >= 100) begin
                lat = -1;
                fin = 1'b1;
            end
        end
        res = result;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = 3'd0; operand_a = '0; operand_b = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result got=%h want=0", result); end
        rst = 1'b0;
    endtask

    task automatic test_multiply();
        logic [2:0]  fs [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [31:0] as [4] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] es [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] res;
        int lat;
        bit bok;
        for (int i = 0; i < 4; i++) begin
            run_op(fs[i], as[i], bs[i], 1'b1, res, lat, bok);
            n_cmp++; if (res !== es[i]) begin n_err++; $display("FAIL mul_result[%0d] got=%h want=%h", i, res, es[i]); end
            n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_latency[%0d] got=%0d want=33", i, lat); end
            n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL mul_busy[%0d] got=%b want=1", i, bok); end
        end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse got=%b want=0", done); end
        n_cmp++; if (result !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL result_hold got=%h want=fffffffe", result); end
    endtask

    task automatic test_divide();
        logic [2:0]  fs [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] es [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] res;
        int lat;
        bit bok;
        for (int i = 0; i < 4; i++) begin
            run_op(fs[i], as[i], bs[i], 1'b1, res, lat, bok);
            n_cmp++; if (res !== es[i]) begin n_err++; $display("FAIL div_result[%0d] got=%h want=%h", i, res, es[i]); end
            n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL div_latency[%0d] got=%0d want=33", i, lat); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  fs [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as [4] = '{32'd5, 32'd5, MinNeg, MinNeg};
        logic [31:0] bs [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] es [4] = '{32'hFFFF_FFFF, 32'd5, MinNeg, 32'd0};
        logic [31:0] res;
        int lat;
        bit bok;
        for (int i = 0; i < 4; i++) begin
            run_op(fs[i], as[i], bs[i], 1'b1, res, lat, bok);
            n_cmp++; if (res !== es[i]) begin n_err++; $display("FAIL special_result[%0d] got=%h want=%h", i, res, es[i]); end
            n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL special_latency[%0d] got=%0d want=1", i, lat); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev, res, a2, b2;
        int lat;
        bit bok, saw_done;
        prev = result;
        // flush and start together in IDLE: nothing accepted
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd5; operand_a = 32'd50; operand_b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_start_busy got=%b want=0", busy); end
        // flush in the 10th CALC cycle of a DIV
        start = 1'b1; funct3 = 3'd4; operand_a = $urandom; operand_b = 32'($urandom_range(1, 1000));
        saw_done = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) saw_done = 1'b1;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got=%b want=0", busy); end
        n_cmp++; if ((done | saw_done) !== 1'b0) begin n_err++; $display("FAIL flush_done got=%b want=0", done | saw_done); end
        n_cmp++; if (result !== prev) begin n_err++; $display("FAIL flush_result got=%h want=%h", result, prev); end
        a2 = $urandom;
        b2 = 32'($urandom_range(1, 100000));
        run_op(3'd6, a2, b2, 1'b0, res, lat, bok);
        n_cmp++; if (res !== ref_op(3'd6, a2, b2)) begin n_err++; $display("FAIL after_flush_result got=%h want=%h", res, ref_op(3'd6, a2, b2)); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL after_flush_latency got=%0d want=33", lat); end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] a, b;
        int lat;
        bit fin, idle_ok;
        a = $urandom;
        b = $urandom;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd3; operand_a = a; operand_b = b;
        lat = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1 || lat >= 100) begin
                fin = 1'b1;
                start = 1'b0;
            end else begin
                start = 1'($urandom_range(0, 1));
                funct3 = 3'($urandom_range(0, 7));
                operand_a = $urandom;
                operand_b = $urandom;
            end
        end
        n_cmp++; if (result !== ref_op(3'd3, a, b)) begin n_err++; $display("FAIL busy_start_result got=%h want=%h", result, ref_op(3'd3, a, b)); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL busy_start_latency got=%0d want=33", lat); end
        idle_ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0) idle_ok = 1'b0;
        end
        n_cmp++; if (idle_ok !== 1'b1) begin n_err++; $display("FAIL busy_start_idle got=%b want=1", idle_ok); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b, res;
        int lat;
        bit bok;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; operand_a = $urandom; operand_b = $urandom;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done got=%b want=0", done); end
        n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL midreset_result got=%h want=0", result); end
        a = $urandom;
        b = $urandom;
        run_op(3'd3, a, b, 1'b1, res, lat, bok);
        n_cmp++; if (res !== ref_op(3'd3, a, b)) begin n_err++; $display("FAIL midreset_mulhu got=%h want=%h", res, ref_op(3'd3, a, b)); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL midreset_latency got=%0d want=33", lat); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f;
        logic [31:0] a, b, res;
        int lat;
        bit bok;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            run_op(f, a, b, 1'b1, res, lat, bok);
            n_cmp++; if (res !== ref_op(f, a, b)) begin n_err++; $display("FAIL rand_result[%0d] f=%0d a=%h b=%h got=%h want=%h", i, f, a, b, res, ref_op(f, a, b)); end
            n_cmp++; if (lat !== ref_lat(f, a, b)) begin n_err++; $display("FAIL rand_latency[%0d] f=%0d got=%0d want=%0d", i, f, lat, ref_lat(f, a, b)); end
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_special();
        test_flush();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
